// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the shared-multiplier scheduler.
package mul_sched_pkg;

   localparam int OP_W   = 8;
   localparam int PROD_W = 16;
   // Tag id field is sized for the largest supported requester count (8).
   localparam int ID_W   = 3;

   // Index width needed to address n requesters (at least one bit).
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first eligible index at or after ptr wins.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] elig,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx,
   output logic         grant_any
);

   // Scan ptr, ptr+1, ... (mod N) and stop at the first eligible requester.
   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!grant_any && elig[idx]) begin
            grant_any  = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = W'(idx);
         end
      end
   end

endmodule

// File: rtl/mul_share_sched.sv
// Shares one fixed-latency pipelined multiplier among N_REQ requesters.
// A tag pipe follows each operation through the multiplier so the product
// lands in its owner's result register, held until the owner accepts it.
module mul_share_sched
   import mul_sched_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*OP_W-1:0]     req_a,
   input  logic [N_REQ*OP_W-1:0]     req_b,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          resp_valid,
   output logic [N_REQ*PROD_W-1:0]   resp_product,
   input  logic [N_REQ-1:0]          resp_ready,
   output logic [OP_W-1:0]           mul_a,
   output logic [OP_W-1:0]           mul_b,
   output logic                      mul_valid_in,
   input  logic [PROD_W-1:0]         mul_product,
   input  logic                      mul_valid_out,
   output logic [CNT_W-1:0]          ops_done,
   output logic                      err
);

   localparam int IW = id_width(N_REQ);

   logic [IW-1:0]    ptr;
   logic [IW-1:0]    grant_idx;
   logic             grant_any;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] busy;
   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] resp_hs;
   logic [N_REQ-1:0] hit;
   logic [CNT_W-1:0] hs_cnt;
   logic             err_now;
   tag_t             tag_p [MUL_LAT+1];
   tag_t             tag_last;

   // A requester with a result still outstanding is never re-granted.
   assign elig     = req_valid & ~busy;
   assign resp_hs  = resp_valid & resp_ready;
   assign tag_last = tag_p[MUL_LAT];

   rr_arbiter #(.N(N_REQ), .W(IW)) u_arb (
      .elig      (elig),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // No grant is offered while reset is held.
   assign req_ready = rst ? '0 : grant;

   // Decode the returning tag, count response handshakes, detect protocol errors.
   always_comb begin
      hit    = '0;
      hs_cnt = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (mul_valid_out && (tag_last.id == ID_W'(i)))
            hit[i] = 1'b1;
         hs_cnt = hs_cnt + CNT_W'(resp_hs[i]);
      end
      err_now = (mul_valid_out != tag_last.vld) || (|(hit & resp_valid));
   end

   // Issue stage: register the granted operand pair and advance the pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr          <= '0;
         mul_a        <= '0;
         mul_b        <= '0;
         mul_valid_in <= 1'b0;
      end else begin
         mul_valid_in <= grant_any;
         if (grant_any) begin
            mul_a <= req_a[OP_W*int'(grant_idx) +: OP_W];
            mul_b <= req_b[OP_W*int'(grant_idx) +: OP_W];
            ptr   <= (grant_idx == IW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   // Busy flags: set on grant, cleared when the owner accepts its result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy <= '0;
      else
         busy <= (busy & ~resp_hs) | grant;
   end

   // Tag pipe: MUL_LAT+1 stages so the last stage lines up with mul_valid_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j <= MUL_LAT; j++)
            tag_p[j] <= '0;
      end else begin
         tag_p[0] <= {grant_any, grant_any ? ID_W'(grant_idx) : ID_W'(0)};
         for (int j = 1; j <= MUL_LAT; j++)
            tag_p[j] <= tag_p[j-1];
      end
   end

   // Return path: capture products into the owner's register; hold until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid   <= '0;
         resp_product <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (resp_hs[i])
               resp_valid[i] <= 1'b0;
            if (hit[i]) begin
               resp_valid[i]                   <= 1'b1;
               resp_product[PROD_W*i +: PROD_W] <= mul_product;
            end
         end
      end
   end

   // Delivered-result counter (wraps) and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ops_done <= '0;
         err      <= 1'b0;
      end else begin
         ops_done <= ops_done + hs_cnt;
         if (err_now)
            err <= 1'b1;
      end
   end

endmodule
